// File: rtl/rr_lmsm_sequencer.sv
// Register-read stage sequencer: expands LM/SM into one micro-op per set list bit.
// Optional base-register write-back micro-op enabled by defining RR_LMSM_BASE_WB_EN.
module rr_lmsm_sequencer #(
  parameter logic [15:0] ADDR_STEP = 16'd1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_Validity,
  input  logic [15:0] in_pc,
  input  logic [15:0] in_IW,
  input  logic [1:0]  in_LMStart,
  input  logic [2:0]  in_RDest,
  input  logic        in_W_reg,
  input  logic        in_W_mem,
  input  logic [15:0] in_RA_data,
  input  logic        stall_RR,
  input  logic        flush,
  output logic        stall_ID,
  output logic        out_Validity,
  output logic [15:0] out_pc,
  output logic [15:0] out_IW,
  output logic [2:0]  out_RDest,
  output logic [2:0]  out_RSrc,
  output logic [15:0] out_addr,
  output logic        out_W_reg,
  output logic        out_W_mem,
  output logic        out_last,
  output logic [1:0]  dbg_state
);

`ifdef RR_LMSM_BASE_WB_EN
  typedef enum logic [1:0] {IDLE = 2'd0, SEQ = 2'd1, WB = 2'd2} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, SEQ = 2'd1} state_t;
`endif

  typedef struct packed {
    logic        valid;
    logic [15:0] pc;
    logic [15:0] iw;
    logic [2:0]  rdest;
    logic [2:0]  rsrc;
    logic [15:0] addr;
    logic        w_reg;
    logic        w_mem;
    logic        last;
  } uop_t;

  state_t      state_q, state_d;
  logic [7:0]  rem_q, rem_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] cap_pc_q, cap_pc_d;
  logic [15:0] cap_iw_q, cap_iw_d;
  logic        cap_sm_q, cap_sm_d;
  uop_t        uop_q, uop_d;

  // Emission source: the live ID/RR inputs in IDLE, the captured copy in SEQ.
  logic        from_seq;
  logic        is_lmsm;
  logic        do_emit;
  logic [7:0]  e_list;
  logic [7:0]  e_rem;
  logic [2:0]  e_idx;
  logic [15:0] e_base;
  logic [15:0] e_pc;
  logic [15:0] e_iw;
  logic        e_sm;

  function automatic logic [2:0] low_idx(input logic [7:0] v);
    logic [2:0] r;
    r = 3'd0;
    for (int k = 7; k >= 0; k--) begin
      if (v[k]) r = 3'(k);
    end
    return r;
  endfunction

  always_comb begin
    from_seq = (state_q == SEQ);
    is_lmsm  = (in_LMStart == 2'b01) || (in_LMStart == 2'b10);
    e_list   = from_seq ? rem_q    : in_IW[7:0];
    e_base   = from_seq ? addr_q   : in_RA_data;
    e_pc     = from_seq ? cap_pc_q : in_pc;
    e_iw     = from_seq ? cap_iw_q : in_IW;
    e_sm     = from_seq ? cap_sm_q : in_LMStart[1];
    e_idx    = low_idx(e_list);
    e_rem    = e_list & ~(8'd1 << e_idx);
  end

  always_comb begin
    state_d  = state_q;
    rem_d    = rem_q;
    addr_d   = addr_q;
    cap_pc_d = cap_pc_q;
    cap_iw_d = cap_iw_q;
    cap_sm_d = cap_sm_q;
    uop_d    = uop_q;
    do_emit  = 1'b0;

    if (flush) begin
      state_d     = IDLE;
      rem_d       = 8'd0;
      uop_d.valid = 1'b0;
    end else if (!stall_RR) begin
      case (state_q)
        IDLE: begin
          if (!in_Validity) begin
            uop_d.valid = 1'b0;
          end else if (!is_lmsm) begin
            uop_d.valid = 1'b1;
            uop_d.pc    = in_pc;
            uop_d.iw    = in_IW;
            uop_d.rdest = in_RDest;
            uop_d.rsrc  = 3'd0;
            uop_d.addr  = 16'd0;
            uop_d.w_reg = in_W_reg;
            uop_d.w_mem = in_W_mem;
            uop_d.last  = 1'b1;
          end else if (in_IW[7:0] == 8'd0) begin
            uop_d.valid = 1'b0;
          end else begin
            cap_pc_d = in_pc;
            cap_iw_d = in_IW;
            cap_sm_d = in_LMStart[1];
            do_emit  = 1'b1;
          end
        end
        SEQ: do_emit = 1'b1;
`ifdef RR_LMSM_BASE_WB_EN
        WB: begin
          uop_d.valid = 1'b1;
          uop_d.pc    = cap_pc_q;
          uop_d.iw    = cap_iw_q;
          uop_d.rdest = cap_iw_q[11:9];
          uop_d.rsrc  = 3'd0;
          uop_d.addr  = addr_q;
          uop_d.w_reg = 1'b1;
          uop_d.w_mem = 1'b0;
          uop_d.last  = 1'b1;
          state_d     = IDLE;
        end
`endif
        default: state_d = IDLE;
      endcase

      if (do_emit) begin
        uop_d.valid = 1'b1;
        uop_d.pc    = e_pc;
        uop_d.iw    = e_iw;
        uop_d.rdest = e_sm ? 3'd0 : e_idx;
        uop_d.rsrc  = e_sm ? e_idx : 3'd0;
        uop_d.addr  = e_base;
        uop_d.w_reg = !e_sm;
        uop_d.w_mem = e_sm;
        rem_d       = e_rem;
        addr_d      = e_base + ADDR_STEP;
        if (e_rem != 8'd0) begin
          uop_d.last = 1'b0;
          state_d    = SEQ;
        end else begin
`ifdef RR_LMSM_BASE_WB_EN
          uop_d.last = 1'b0;
          state_d    = WB;
`else
          uop_d.last = 1'b1;
          state_d    = IDLE;
`endif
        end
      end
    end
  end

  // Falling-edge update, matching the other pipeline registers.
  always_ff @(negedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      rem_q    <= 8'd0;
      addr_q   <= 16'd0;
      cap_pc_q <= 16'd0;
      cap_iw_q <= 16'd0;
      cap_sm_q <= 1'b0;
      uop_q    <= '0;
    end else begin
      state_q  <= state_d;
      rem_q    <= rem_d;
      addr_q   <= addr_d;
      cap_pc_q <= cap_pc_d;
      cap_iw_q <= cap_iw_d;
      cap_sm_q <= cap_sm_d;
      uop_q    <= uop_d;
    end
  end

  assign stall_ID     = (state_q != IDLE) || stall_RR;
  assign out_Validity = uop_q.valid;
  assign out_pc       = uop_q.pc;
  assign out_IW       = uop_q.iw;
  assign out_RDest    = uop_q.rdest;
  assign out_RSrc     = uop_q.rsrc;
  assign out_addr     = uop_q.addr;
  assign out_W_reg    = uop_q.w_reg;
  assign out_W_mem    = uop_q.w_mem;
  assign out_last     = uop_q.last;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_rr_lmsm_sequencer.sv
// Directed bench for rr_lmsm_sequencer: driver pushes expected micro-ops, monitor pops and compares.
module tb_rr_lmsm_sequencer;

`ifdef RR_LMSM_BASE_WB_EN
  localparam bit WB_EN = 1'b1;
`else
  localparam bit WB_EN = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic        in_Validity;
  logic [15:0] in_pc;
  logic [15:0] in_IW;
  logic [1:0]  in_LMStart;
  logic [2:0]  in_RDest;
  logic        in_W_reg;
  logic        in_W_mem;
  logic [15:0] in_RA_data;
  logic        stall_RR;
  logic        flush;
  logic        stall_ID;
  logic        out_Validity;
  logic [15:0] out_pc;
  logic [15:0] out_IW;
  logic [2:0]  out_RDest;
  logic [2:0]  out_RSrc;
  logic [15:0] out_addr;
  logic        out_W_reg;
  logic        out_W_mem;
  logic        out_last;
  logic [1:0]  dbg_state;

  // {pc, iw, rdest, rsrc, addr, w_reg, w_mem, last}
  localparam int W = 57;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] last_exp;
  logic         have_last;
  logic         stall_seen;
  int           checks;
  int           passes;
  int           n;

  rr_lmsm_sequencer dut (
    .clk(clk), .reset(reset), .in_Validity(in_Validity), .in_pc(in_pc), .in_IW(in_IW),
    .in_LMStart(in_LMStart), .in_RDest(in_RDest), .in_W_reg(in_W_reg), .in_W_mem(in_W_mem),
    .in_RA_data(in_RA_data), .stall_RR(stall_RR), .flush(flush), .stall_ID(stall_ID),
    .out_Validity(out_Validity), .out_pc(out_pc), .out_IW(out_IW), .out_RDest(out_RDest),
    .out_RSrc(out_RSrc), .out_addr(out_addr), .out_W_reg(out_W_reg), .out_W_mem(out_W_mem),
    .out_last(out_last), .dbg_state(dbg_state)
  );

  // Clock and reset
  initial clk = 1'b1;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish (checks=%0d)", checks);
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Driver tasks
  task automatic tick();
    @(negedge clk);
    #2;
  endtask

  task automatic set_in(input logic v, input logic [15:0] pc, input logic [15:0] iw,
                        input logic [1:0] ls, input logic [2:0] rd, input logic wr,
                        input logic wm, input logic [15:0] ra);
    in_Validity = v;
    in_pc       = pc;
    in_IW       = iw;
    in_LMStart  = ls;
    in_RDest    = rd;
    in_W_reg    = wr;
    in_W_mem    = wm;
    in_RA_data  = ra;
  endtask

  task automatic idle_in();
    in_Validity = 1'b0;
  endtask

  task automatic push(input logic [15:0] pc, input logic [15:0] iw, input logic [2:0] rd,
                      input logic [2:0] rs, input logic [15:0] addr, input logic wr,
                      input logic wm, input logic last);
    exp_q.push_back({pc, iw, rd, rs, addr, wr, wm, last});
  endtask

  task automatic wait_idle(output int cnt);
    cnt = 0;
    while (stall_ID && cnt < 40) begin
      tick();
      cnt++;
    end
  endtask

  // Scoreboard monitor: a fresh micro-op is any valid output not produced under stall_RR.
  always @(negedge clk) stall_seen = stall_RR;

  always @(posedge clk) begin
    logic [W-1:0] act;
    logic [W-1:0] e;
    act = {out_pc, out_IW, out_RDest, out_RSrc, out_addr, out_W_reg, out_W_mem, out_last};
    if (reset === 1'b0 && out_Validity === 1'b1) begin
      if (stall_seen && have_last) begin
        chk("frozen_uop", 64'(act), 64'(last_exp));
      end else if (exp_q.size() == 0) begin
        chk("unexpected_uop", 64'(act), 64'(0));
      end else begin
        e = exp_q.pop_front();
        chk("uop", 64'(act), 64'(e));
        last_exp  = e;
        have_last = 1'b1;
      end
    end
  end

  initial begin
    checks = 0; passes = 0; have_last = 1'b0; stall_seen = 1'b0;
    reset = 1'b1; stall_RR = 1'b0; flush = 1'b0;
    set_in(1'b0, 16'h0, 16'h0, 2'b00, 3'd0, 1'b0, 1'b0, 16'h0);
    tick(); tick();
    chk("reset_outputs", 64'({out_Validity, out_pc, out_IW, out_RDest, out_RSrc, out_addr,
                              out_W_reg, out_W_mem, out_last}), 64'(0));
    chk("reset_stall_id", 64'(stall_ID), 64'(0));
    reset = 1'b0;

    // Normal ADD pass-through, then bubble holds other outputs
    set_in(1'b1, 16'h0010, 16'h1234, 2'b00, 3'd3, 1'b1, 1'b0, 16'h9999);
    #1 chk("add_stall_id_before", 64'(stall_ID), 64'(0));
    push(16'h0010, 16'h1234, 3'd3, 3'd0, 16'h0000, 1'b1, 1'b0, 1'b1);
    tick();
    idle_in();
    #1 chk("add_stall_id_after", 64'(stall_ID), 64'(0));
    tick();
    chk("bubble_valid", 64'(out_Validity), 64'(0));
    chk("bubble_hold", 64'({out_pc, out_RDest, out_W_reg}), 64'({16'h0010, 3'd3, 1'b1}));

    // Reserved kind is a normal pass-through; empty LM list is a NOP
    set_in(1'b1, 16'h0014, 16'hF0AB, 2'b11, 3'd4, 1'b0, 1'b1, 16'h5555);
    push(16'h0014, 16'hF0AB, 3'd4, 3'd0, 16'h0000, 1'b0, 1'b1, 1'b1);
    tick();
    set_in(1'b1, 16'h0016, 16'h6200, 2'b01, 3'd0, 1'b0, 1'b0, 16'h0077);
    tick();
    chk("empty_lm_valid", 64'(out_Validity), 64'(0));
    chk("empty_lm_stall_id", 64'(stall_ID), 64'(0));
    idle_in();
    tick();

    // LM 1000_0101 from 0x0040 (RA=2), followed by a normal op held in ID/RR
    set_in(1'b1, 16'h0020, 16'h6485, 2'b01, 3'd0, 1'b0, 1'b0, 16'h0040);
    push(16'h0020, 16'h6485, 3'd0, 3'd0, 16'h0040, 1'b1, 1'b0, 1'b0);
    push(16'h0020, 16'h6485, 3'd2, 3'd0, 16'h0041, 1'b1, 1'b0, 1'b0);
    push(16'h0020, 16'h6485, 3'd7, 3'd0, 16'h0042, 1'b1, 1'b0, !WB_EN);
    if (WB_EN) push(16'h0020, 16'h6485, 3'd2, 3'd0, 16'h0043, 1'b1, 1'b0, 1'b1);
    tick();
    set_in(1'b1, 16'h0022, 16'h1111, 2'b00, 3'd5, 1'b1, 1'b0, 16'h0000);
    push(16'h0022, 16'h1111, 3'd5, 3'd0, 16'h0000, 1'b1, 1'b0, 1'b1);
    wait_idle(n);
    chk("lm85_stall_len", 64'(n), 64'(WB_EN ? 3 : 2));
    tick();
    idle_in();
    tick();

    // SM list 0x01 at 0xFFFF (RA=5): write-back address wraps to 0
    set_in(1'b1, 16'h0030, 16'h7A01, 2'b10, 3'd0, 1'b0, 1'b0, 16'hFFFF);
    push(16'h0030, 16'h7A01, 3'd0, 3'd0, 16'hFFFF, 1'b0, 1'b1, !WB_EN);
    if (WB_EN) push(16'h0030, 16'h7A01, 3'd5, 3'd0, 16'h0000, 1'b1, 1'b0, 1'b1);
    tick();
    idle_in();
    wait_idle(n);
    chk("sm01_stall_len", 64'(n), 64'(WB_EN ? 1 : 0));
    tick();

    // SM list 0x12 from 0x1000 (RA=1): sources R1 then R4
    set_in(1'b1, 16'h0034, 16'h7212, 2'b10, 3'd0, 1'b0, 1'b0, 16'h1000);
    push(16'h0034, 16'h7212, 3'd0, 3'd1, 16'h1000, 1'b0, 1'b1, 1'b0);
    push(16'h0034, 16'h7212, 3'd0, 3'd4, 16'h1001, 1'b0, 1'b1, !WB_EN);
    if (WB_EN) push(16'h0034, 16'h7212, 3'd1, 3'd0, 16'h1002, 1'b1, 1'b0, 1'b1);
    tick();
    idle_in();
    wait_idle(n);
    chk("sm12_stall_len", 64'(n), 64'(WB_EN ? 2 : 1));
    tick();

    // LM 0xFF from 0x0100 (RA=3), stall_RR for 3 edges after the 2nd micro-op
    set_in(1'b1, 16'h0040, 16'h66FF, 2'b01, 3'd0, 1'b0, 1'b0, 16'h0100);
    for (int k = 0; k < 8; k++)
      push(16'h0040, 16'h66FF, 3'(k), 3'd0, 16'h0100 + 16'(k), 1'b1, 1'b0, (k == 7) && !WB_EN);
    if (WB_EN) push(16'h0040, 16'h66FF, 3'd3, 3'd0, 16'h0108, 1'b1, 1'b0, 1'b1);
    tick();
    idle_in();
    tick();
    stall_RR = 1'b1;
    tick(); tick(); tick();
    stall_RR = 1'b0;
    wait_idle(n);
    chk("lmff_stall_len", 64'(n), 64'(WB_EN ? 7 : 6));
    tick();

    // LM 0x0F from 0x0200 (RA=4), flush on the 2nd edge
    set_in(1'b1, 16'h0050, 16'h680F, 2'b01, 3'd0, 1'b0, 1'b0, 16'h0200);
    push(16'h0050, 16'h680F, 3'd0, 3'd0, 16'h0200, 1'b1, 1'b0, 1'b0);
    tick();
    flush = 1'b1;
    set_in(1'b1, 16'h0052, 16'h2222, 2'b00, 3'd1, 1'b1, 1'b0, 16'h0000);
    tick();
    flush = 1'b0;
    chk("flush_valid", 64'(out_Validity), 64'(0));
    chk("flush_stall_id", 64'(stall_ID), 64'(0));
    set_in(1'b1, 16'h0060, 16'h3333, 2'b00, 3'd6, 1'b1, 1'b0, 16'h0000);
    push(16'h0060, 16'h3333, 3'd6, 3'd0, 16'h0000, 1'b1, 1'b0, 1'b1);
    tick();
    idle_in();
    tick(); tick();

    // LM 0xF0 from 0x0300 (RA=0), reset pulsed after the 2nd micro-op
    set_in(1'b1, 16'h0070, 16'h60F0, 2'b01, 3'd0, 1'b0, 1'b0, 16'h0300);
    push(16'h0070, 16'h60F0, 3'd4, 3'd0, 16'h0300, 1'b1, 1'b0, 1'b0);
    push(16'h0070, 16'h60F0, 3'd5, 3'd0, 16'h0301, 1'b1, 1'b0, 1'b0);
    tick();
    idle_in();
    tick();
    @(posedge clk);
    #1 reset = 1'b1;
    #1;
    chk("reset_mid_outputs", 64'({out_Validity, out_pc, out_IW, out_RDest, out_RSrc, out_addr,
                                  out_W_reg, out_W_mem, out_last}), 64'(0));
    chk("reset_mid_stall_id", 64'(stall_ID), 64'(0));
    tick();
    reset = 1'b0;
    tick(); tick();
    set_in(1'b1, 16'h0080, 16'h6000, 2'b01, 3'd0, 1'b0, 1'b0, 16'h0400);
    tick();
    chk("post_reset_empty_lm_valid", 64'(out_Validity), 64'(0));
    chk("post_reset_empty_lm_stall_id", 64'(stall_ID), 64'(0));
    idle_in();
    tick(); tick();

    // Final report
    chk("queue_drained", 64'(exp_q.size()), 64'(0));
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/rr_lmsm_sequencer.md
# rr_lmsm_sequencer

Register-read-side consumer of the ID/RR pipeline register. It expands a valid Load-Multiple (LM) or Store-Multiple (SM) instruction into one micro-op per set bit of its 8-bit register list. While sequencing, it holds the ID/RR register through `stall_ID`. All other valid instructions pass through unchanged as single micro-ops into the RR/EX boundary.

## Interface
Parameters:
- ADDR_STEP, 16'd1, address increment between consecutive transfers (word addressing)

Ports:
- clk  in  1  pipeline clock; all state updates on the falling edge, as for every pipeline register
- reset  in  1  asynchronous, active-high; one clock; polarity and synchronicity are fixed
- in_Validity  in  1  ID/RR holds a valid instruction
- in_pc  in  16  PC of the held instruction
- in_IW  in  16  instruction word; IW[11:9] is RA (base), IW[7:0] is the register list
- in_LMStart  in  2  00 = normal, 01 = LM, 10 = SM, 11 = reserved (treated as normal)
- in_RDest  in  3  destination for normal instructions
- in_W_reg, in_W_mem  in  1 each  write enables for normal instructions
- in_RA_data  in  16  register-file value of RA, valid whenever in_Validity=1
- stall_RR  in  1  downstream hold; freezes all state and outputs
- flush  in  1  squash from branch/jump resolution
- stall_ID  out  1  combinational: (state != IDLE) OR stall_RR
- out_Validity  out  1  micro-op valid
- out_pc, out_IW  out  16 each  copied from the originating instruction
- out_RDest  out  3  LM destination register, or in_RDest for normal instructions
- out_RSrc  out  3  SM source register index (regfile read port B); 0 otherwise
- out_addr  out  16  memory address for the LM/SM micro-op; 0 otherwise
- out_W_reg, out_W_mem  out  1 each  LM: 1/0; SM: 0/1; normal: pass-through
- out_last  out  1  final micro-op of an instruction (always 1 for normal instructions)

## Operation
- States: IDLE, SEQ, WB (WB exists only with the macro defined).
- Internal registers: remaining list `rem[7:0]`, next address `addr[15:0]`, captured pc/IW/RA/kind.
- Priority: reset > flush > stall_RR > normal stepping.

IDLE, on an edge with in_Validity=1:
- Normal instruction:
  - Emit a pass-through micro-op.
  - out_Validity=1, out_last=1, out_RSrc=0, out_addr=0.
- LM/SM with a non-zero list:
  - Emit a micro-op for the lowest set bit i (IW bit i selects Ri).
  - out_addr = in_RA_data.
  - rem = list with bit i cleared; addr = in_RA_data + ADDR_STEP (mod 2^16, wraps silently).
  - If rem ≠ 0 → SEQ, else out_last=1 and → IDLE (or → WB with the macro).
- LM/SM with an empty list: out_Validity=0, treated as a NOP, stay in IDLE.

IDLE, on an edge with in_Validity=0:
- out_Validity=0. All other outputs hold their values.

SEQ, each edge:
- Emit the micro-op for the lowest set bit of rem, at out_addr = addr.
- Clear that bit from rem; addr += ADDR_STEP.
- When the emitted bit was the last: out_last=1 and → IDLE (or → WB).

Other rules:
- flush=1 on an edge: → IDLE, rem=0, out_Validity=0. This applies in any state, including while in_Validity=1.
- stall_RR=1: no state, rem, addr or output change.

## Timing
- Reset value of every output: 0. State returns to IDLE and rem=0 immediately (asynchronous).
- Reset in the middle of a sequence abandons it; no further micro-ops are emitted.
- Latency: micro-op k of an N-register LM/SM appears k+1 falling edges after the edge on which the instruction was first seen. Output is registered.
- Throughput: one micro-op per edge.
- An N-bit list stalls ID for N−1 edges (N edges with the macro).
- stall_ID is high on the edge that emits the last SEQ micro-op. This holds the following instruction in ID/RR, and it is consumed on the next edge with no bubble.

## Configuration
- RR_LMSM_BASE_WB_EN defined:
  - After the last transfer, → WB and emit one extra micro-op.
  - That micro-op: out_RDest=RA, out_W_reg=1, out_W_mem=0, out_addr = final addr (the write-back value), out_last=1.
  - Then → IDLE.
  - out_last is 0 on the preceding transfer micro-op.
- RR_LMSM_BASE_WB_EN undefined: no WB state, and RA is never updated.

## Test plan
- Normal ADD (in_LMStart=00, in_RDest=3, in_W_reg=1), valid for one edge → one micro-op with out_RDest=3, out_last=1; stall_ID stays 0.
- LM, list 8'b1000_0101, RA_data=16'h0040 → three micro-ops with RDest 0/2/7 at addresses 0040/0041/0042; stall_ID high for exactly 2 edges; out_last only on the third.
- SM, list 8'h01, RA_data=16'hFFFF, macro defined → SM micro-op with RSrc=0 at FFFF, then a WB micro-op with RDest=RA and address 0000 (wrap).
- LM, list 8'hFF, stall_RR held high for 3 edges after the 2nd micro-op → outputs frozen, then the remaining 6 micro-ops follow in order.
- LM, list 8'h0F, flush asserted on the 2nd edge → out_Validity=0 from that edge on, stall_ID drops, and the next ID/RR instruction is consumed.
- LM, list 8'hF0, reset pulsed mid-sequence → all outputs 0 at once; after release, an LM with an empty list gives out_Validity=0.
